r16_tf_mul_ctrl: RTL
====================

# r16_tf_mul_ctrl

Sequencing controller for the radix-16 twiddle-factor multiplier array. It accepts one stage command, admits 16-point groups from the upstream delay-commutator under credit-based flow control, and issues twiddle-ROM addresses in lockstep. Because the MulMod128 pipeline has no enable, admission is the only throttle. The controller tracks every in-flight group through the fixed-latency multiplier pipeline and flags valid/last at its output.

## Interface
- GW, 10, group-counter width; a stage holds at most 2^GW groups.
- TF_AW, 12, twiddle-ROM address width.
- TF_RD_LAT, 1, twiddle-ROM read latency in cycles.
- MUL_LAT, 3, MulMod128 latency; equals the lane-0 delay line depth.
- CREDITS, 8, downstream buffer depth in groups; range 1..255.
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid / cmd_ready  in/out  1  stage-command handshake.
- cmd_groups  in  GW+1  number of groups; legal range 1..2^GW.
- cmd_tf_base, cmd_tf_stride  in  TF_AW  first ROM address and per-group increment.
- cmd_bypass  in  1  stage with unity twiddles.
- in_valid / in_ready  in/out  1  group admission; one group of 16 words per handshake.
- tf_addr  out  TF_AW  twiddle-ROM address.
- tf_rd_en  out  1  twiddle-ROM read strobe.
- tf_sel_one  out  1  forces TF inputs to constant 1.
- out_valid, out_last  out  1  group present at the multiplier outputs; last group of the stage.
- credit_ret  in  1  downstream freed one group slot.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse when the stage has fully drained.

## Operation
- FSM states: IDLE, RUN, DRAIN.
- IDLE
  - cmd_ready=1, in_ready=0.
  - On cmd_valid, latch the command, clear the group counter g, load addr=cmd_tf_base, go to RUN.
- RUN
  - in_ready=1 iff credit count != 0.
  - Each admission handshake:
    - push {1, last} into the valid pipe; last=1 when g==groups-1.
    - Register tf_addr=addr, tf_rd_en=!bypass, tf_sel_one=bypass for one cycle.
    - Update addr=addr+stride (mod 2^TF_AW, wrap silently) and g=g+1.
  - After the handshake with last=1, go to DRAIN.
- DRAIN
  - in_ready=0.
  - When the valid pipe is empty, pulse done and go to IDLE.
- Credits
  - Counter resets to CREDITS.
  - Decrement on admission; increment on credit_ret; both in the same cycle leaves it unchanged.
  - credit_ret at CREDITS is ignored (saturate).
  - Credits persist across commands.
- Commands are accepted only in IDLE; cmd_valid in other states is held off (cmd_ready=0).
- cmd_groups=0 is treated as 1.

## Timing
- Admission at cycle t:
  - tf_addr / tf_rd_en / tf_sel_one valid at t+1.
  - out_valid at t+1+TF_RD_LAT+MUL_LAT, i.e. t+5 by default.
  - Upstream data must enter the multipliers aligned to the TF read data.
- Throughput: one group per cycle while credits remain.
- done is asserted the cycle after out_valid&out_last; busy falls in the same cycle done pulses.
- Reset values: cmd_ready=0 while rst is high, 1 after; in_ready=0, tf_addr=0, tf_rd_en=0, tf_sel_one=0, out_valid=0, out_last=0, busy=0, done=0. Credits=CREDITS, FSM=IDLE.
- Reset asserted mid-stage discards all in-flight groups; no out_valid follows.

## Configuration
- R16_TF_CTRL_PERF_EN defined: adds outputs perf_stall_cycles (32 b) and perf_groups (32 b).
  - perf_stall_cycles counts RUN cycles with in_valid=1 and credits=0.
  - perf_groups counts admissions.
  - Both saturate and are cleared by rst only.
- Undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package r16_tf_pkg holds:
  - FSM state enum.
  - default GW, TF_AW, TF_RD_LAT and MUL_LAT constants; MUL_LAT is also used by the multiplier array.
- One sub-module: r16_valid_pipe, a parameterised-depth {valid,last} shift register with an any-valid flag, reset to 0.

## Test plan
- Reset, then a command with groups=4, base=0x010, stride=0x003, bypass=0, in_valid held high.
  - Expect tf_addr 0x010, 0x013, 0x016, 0x019 at t+1..t+4.
  - Expect out_valid t+5..t+8 with out_last at t+8, and done at t+9.
- CREDITS=2, no credit_ret, groups=5.
  - Expect exactly 2 admissions, then in_ready=0.
  - A single credit_ret admits exactly one more group.
- Simultaneous credit_ret and admission at credits=1: credits stay 1 and in_ready stays 1.
- Bypass command with groups=3: tf_rd_en stays 0, tf_sel_one=1 on each issue cycle, out_valid timing unchanged.
- Address wrap with base=0xFFE, stride=0x001, TF_AW=12: tf_addr sequence 0xFFE, 0xFFF, 0x000.
- Assert rst for one cycle after 2 of 4 groups are admitted.
  - Expect all outputs at reset values, no out_valid afterwards, credits back to CREDITS, and cmd_ready=1 the cycle after rst deasserts.

Source files
------------

// File: rtl/r16_tf_pkg.sv
// r16_tf_pkg: definitions shared by the radix-16 twiddle-factor multiplier
// sequencing controller and the multiplier array.
//   state_t        - controller FSM states (IDLE, RUN, DRAIN)
//   R16_GW         - default group-counter width
//   R16_TF_AW      - default twiddle-ROM address width
//   R16_TF_RD_LAT  - default twiddle-ROM read latency (cycles)
//   R16_MUL_LAT    - MulMod128 latency; also the lane-0 delay-line depth
//   R16_CREDIT_W   - credit counter width (CREDITS is limited to 1..255)
package r16_tf_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int R16_GW        = 10;
    localparam int R16_TF_AW     = 12;
    localparam int R16_TF_RD_LAT = 1;
    localparam int R16_MUL_LAT   = 3;
    localparam int R16_CREDIT_W  = 8;

endpackage

// File: rtl/r16_valid_pipe.sv
// r16_valid_pipe: {valid,last} shift register that follows each admitted
// group through the twiddle-ROM read and the multiplier pipeline.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   push_valid, push_last - group entering the pipe this cycle
//   out_valid, out_last   - group at the end of the pipe (registered)
//   any_valid             - some group will still be inside the pipe after
//                           the next clock edge (incoming push or any stage
//                           short of the output stage)
module r16_valid_pipe #(
    parameter int DEPTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic push_valid,
    input  logic push_last,
    output logic out_valid,
    output logic out_last,
    output logic any_valid
);

    // Every stage except the output one; those are the groups that remain
    // after the next shift.
    localparam logic [DEPTH-1:0] UPSTREAM_MASK = DEPTH'((1 << (DEPTH - 1)) - 1);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] last_q;

    // NOTE: the stages carry a real reset (not left to power-up) so that a
    // mid-stage reset discards every in-flight group; state is updated with
    // non-blocking assignments so all stages shift on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            last_q  <= '0;
        end else begin
            valid_q <= (valid_q << 1) | DEPTH'(push_valid);
            last_q  <= (last_q << 1) | DEPTH'(push_valid && push_last);
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_last  = last_q[DEPTH-1];
    assign any_valid = push_valid || (|(valid_q & UPSTREAM_MASK));

endmodule

// File: rtl/r16_tf_mul_ctrl.sv
// r16_tf_mul_ctrl: sequencing controller for the radix-16 twiddle-factor
// multiplier array. Accepts one stage command, admits 16-point groups under
// credit flow control, issues twiddle-ROM addresses in lockstep and flags
// valid/last at the multiplier outputs.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            - stage command handshake
//   cmd_groups                     - group count (0 treated as 1)
//   cmd_tf_base, cmd_tf_stride     - first twiddle address, per-group step
//   cmd_bypass                     - unity-twiddle stage
//   in_valid/in_ready              - group admission handshake
//   tf_addr, tf_rd_en, tf_sel_one  - twiddle-ROM address/strobe, force-one
//   out_valid, out_last            - group at multiplier outputs, last group
//   credit_ret                     - downstream freed one group slot
//   busy, done                     - not idle; one-cycle drained pulse
// Optional build macro R16_TF_CTRL_PERF_EN adds perf_stall_cycles and
// perf_groups (32-bit saturating counters, cleared by rst only).
module r16_tf_mul_ctrl
    import r16_tf_pkg::*;
#(
    parameter int GW        = R16_GW,
    parameter int TF_AW     = R16_TF_AW,
    parameter int TF_RD_LAT = R16_TF_RD_LAT,
    parameter int MUL_LAT   = R16_MUL_LAT,
    parameter int CREDITS   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [GW:0]      cmd_groups,
    input  logic [TF_AW-1:0] cmd_tf_base,
    input  logic [TF_AW-1:0] cmd_tf_stride,
    input  logic             cmd_bypass,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [TF_AW-1:0] tf_addr,
    output logic             tf_rd_en,
    output logic             tf_sel_one,
    output logic             out_valid,
    output logic             out_last,
    input  logic             credit_ret,
    output logic             busy,
    output logic             done
`ifdef R16_TF_CTRL_PERF_EN
    ,
    output logic [31:0]      perf_stall_cycles,
    output logic [31:0]      perf_groups
`endif
);

    // Issue register + ROM read + multiplier: admission to out_valid.
    localparam int PIPE_DEPTH = 1 + TF_RD_LAT + MUL_LAT;
    localparam logic [R16_CREDIT_W-1:0] CREDIT_MAX = R16_CREDIT_W'(CREDITS);

    state_t                  state;
    logic [GW:0]             groups_m1;
    logic [GW:0]             g;
    logic [TF_AW-1:0]        addr;
    logic [TF_AW-1:0]        stride;
    logic                    bypass;
    logic [R16_CREDIT_W-1:0] credits;
    logic [R16_CREDIT_W-1:0] credits_nxt;
    logic                    admit;
    logic                    ret_ok;
    logic                    is_last;
    logic                    pipe_any;

    // in_ready is only ever high in RUN, so a handshake implies RUN.
    assign admit   = in_valid && in_ready;
    assign ret_ok  = credit_ret && (credits != CREDIT_MAX);
    assign is_last = (g == groups_m1);

    // NOTE: default assignment first so no path leaves credits_nxt unassigned
    // (which would infer a latch).
    always_comb begin
        credits_nxt = credits;
        if (admit && !ret_ok) begin
            credits_nxt = credits - 1'b1;
        end else if (ret_ok && !admit) begin
            credits_nxt = credits + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits <= CREDIT_MAX;
        end else begin
            credits <= credits_nxt;
        end
    end

    // Controller FSM; every output is registered. in_ready is computed from
    // the post-edge credit count so it never advertises a slot that is gone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cmd_ready  <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tf_addr    <= '0;
            tf_rd_en   <= 1'b0;
            tf_sel_one <= 1'b0;
            groups_m1  <= '0;
            g          <= '0;
            addr       <= '0;
            stride     <= '0;
            bypass     <= 1'b0;
        end else begin
            done       <= 1'b0;
            tf_rd_en   <= 1'b0;
            tf_sel_one <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (cmd_valid && cmd_ready) begin
                        state     <= RUN;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        in_ready  <= (credits_nxt != '0);
                        groups_m1 <= (cmd_groups == '0) ? '0 : cmd_groups - 1'b1;
                        g         <= '0;
                        addr      <= cmd_tf_base;
                        stride    <= cmd_tf_stride;
                        bypass    <= cmd_bypass;
                    end
                end
                RUN: begin
                    if (admit) begin
                        tf_addr    <= addr;
                        tf_rd_en   <= !bypass;
                        tf_sel_one <= bypass;
                        addr       <= addr + stride;
                        g          <= g + 1'b1;
                    end
                    if (admit && is_last) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end else begin
                        in_ready <= (credits_nxt != '0);
                    end
                end
                DRAIN: begin
                    // pipe_any looks one edge ahead, so done lands the cycle
                    // after the last group leaves the multipliers.
                    if (!pipe_any) begin
                        state     <= IDLE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    r16_valid_pipe #(
        .DEPTH(PIPE_DEPTH)
    ) u_valid_pipe (
        .clk       (clk),
        .rst       (rst),
        .push_valid(admit),
        .push_last (is_last),
        .out_valid (out_valid),
        .out_last  (out_last),
        .any_valid (pipe_any)
    );

`ifdef R16_TF_CTRL_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= '0;
            perf_groups       <= '0;
        end else begin
            if (state == RUN && in_valid && credits == '0 && perf_stall_cycles != '1) begin
                perf_stall_cycles <= perf_stall_cycles + 1'b1;
            end
            if (admit && perf_groups != '1) begin
                perf_groups <= perf_groups + 1'b1;
            end
        end
    end
`endif

endmodule
